// File: rtl/pc_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_pkg
// Shared types and constants for the instruction-fetch front end.
//   PC_W / INSTR_W         : datapath widths
//   DEFAULT_RESET_PC       : default PC loaded on reset
//   DEFAULT_PC_STEP        : default sequential PC increment in bytes
//   state_e                : fetch FSM states
//   align_target()         : clears the byte-offset bits of a redirect target
// -----------------------------------------------------------------------------
package pc_fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [PC_W-1:0] DEFAULT_PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_e;

    function automatic logic [PC_W-1:0] align_target(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_if
// Bundles the two handshakes of the fetch unit:
//   imem_req/imem_addr  -> memory,  imem_ack/imem_rdata <- memory (req/ack)
//   if_valid/if_pc/if_instr -> decode, if_ready <- decode (valid/ready)
// Modports:
//   master : the fetch unit
//   slave  : the memory + decode side
// -----------------------------------------------------------------------------
interface pc_fetch_if;
    import pc_fetch_pkg::*;

    logic                imem_req;
    logic [PC_W-1:0]     imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_rdata;

    logic                if_valid;
    logic [PC_W-1:0]     if_pc;
    logic [INSTR_W-1:0]  if_instr;
    logic                if_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output if_valid, if_pc, if_instr,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  if_valid, if_pc, if_instr,
        output if_ready
    );

endinterface

// File: rtl/pc_fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// One-entry output register holding the PC and instruction word presented
// to decode.
//   clk, rst (sync, active-low)
//   load      : capture pc_in/instr_in at the next rising edge
//   pc_in     : PC of the fetched word
//   instr_in  : fetched instruction word
//   pc_out    : registered PC (if_pc)
//   instr_out : registered instruction (if_instr)
// -----------------------------------------------------------------------------
module fetch_buf
    import pc_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] instr_out
);

    logic [PC_W-1:0]    pc_q,    pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (load) begin
            pc_d    = pc_in;
            instr_d = instr_in;
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // values. The data registers are reset too because decode observes
    // if_pc/if_instr as zero straight out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign pc_out    = pc_q;
    assign instr_out = instr_q;

endmodule

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
// Instruction-fetch front end: owns the program counter, issues fetches on a
// req/ack memory port and presents fetched words to decode on valid/ready.
// Redirects from execute are accepted in every state; fetches that are in
// flight when a redirect arrives are completed on the bus and discarded.
//   clk            : rising-edge clock
//   rst            : synchronous, active-low reset
//   stall          : blocks issue of new fetches
//   redirect_valid : branch/jump taken this cycle
//   redirect_pc    : redirect target
//   misalign_err   : sticky misaligned-redirect flag (only with the macro)
//   bus            : pc_fetch_if.master (imem_* and if_* signals)
// Optional feature: define PC_FETCH_ALIGN_CHECK_EN to add misalign_err and
// force redirect targets to word alignment.
// -----------------------------------------------------------------------------
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [PC_W-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
`ifdef PC_FETCH_ALIGN_CHECK_EN
    output logic            misalign_err,
`endif
    pc_fetch_if.master      bus
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [PC_W-1:0] redirect_tgt;
    logic            buf_load;

`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    always_comb begin
        redirect_tgt = align_target(redirect_pc);
        misalign_d   = misalign_q | (redirect_valid & (|redirect_pc[1:0]));
    end

    always_ff @(posedge clk) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= misalign_d;
    end

    assign misalign_err = misalign_q;
`else
    assign redirect_tgt = redirect_pc;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        buf_load     = 1'b0;
        case (state_q)
            IDLE: begin
                // Redirect updates pc even when stalled.
                if (redirect_valid) pc_d = redirect_tgt;
                if (!stall) begin
                    fetch_addr_d = redirect_valid ? redirect_tgt : pc_q;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    // The request must still be completed on the bus; FLUSH
                    // waits for the ack, a same-cycle ack goes straight home.
                    pc_d    = redirect_tgt;
                    state_d = bus.imem_ack ? IDLE : FLUSH;
                end else if (bus.imem_ack) begin
                    buf_load = 1'b1;
                    pc_d     = fetch_addr_q + PC_STEP;
                    state_d  = HOLD;
                end
            end
            FLUSH: begin
                if (redirect_valid) pc_d = redirect_tgt;
                if (bus.imem_ack)   state_d = IDLE;
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = IDLE;
                end else if (bus.if_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    fetch_buf u_fetch_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .pc_in     (fetch_addr_q),
        .instr_in  (bus.imem_rdata),
        .pc_out    (bus.if_pc),
        .instr_out (bus.if_instr)
    );

    assign bus.imem_req  = (state_q == REQ) || (state_q == FLUSH);
    assign bus.imem_addr = fetch_addr_q;
    assign bus.if_valid  = (state_q == HOLD);

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
// Self-checking bench for pc_fetch. Plays the instruction memory and decode
// stage. A directed vector table covers reset, sequential fetch, wait states,
// backpressure, redirect during a wait, stall, wrap-around and redirects in
// REQ/HOLD; hand sequences cover reset mid-fetch, a redirect overwritten
// during FLUSH and (with PC_FETCH_ALIGN_CHECK_EN) the alignment check; a
// random phase compares against a transaction-level model of the fetch
// stream.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] BAD      = 32'hDEAD_DEAD;
    localparam logic [31:0] A0 = 32'h1000_0013, A1 = 32'h2000_0093,
                            A2 = 32'h3000_0113, A3 = 32'h4000_0193,
                            A4 = 32'h5000_0213, A5 = 32'h6000_0293,
                            A6 = 32'h7000_0313, A7 = 32'h8000_0393,
                            A8 = 32'h9000_0413, A9 = 32'hA000_0493;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    pc_fetch_if u_if ();

    pc_fetch u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (rv),
        .redirect_pc    (rpc),
`ifdef PC_FETCH_ALIGN_CHECK_EN
        .misalign_err   (misalign_err),
`endif
        .bus            (u_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rp,
                         input logic ack, input logic [31:0] rd, input logic rdy);
        stall            = s;
        rv               = r;
        rpc              = rp;
        u_if.imem_ack    = ack;
        u_if.imem_rdata  = rd;
        u_if.if_ready    = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Directed vectors: inputs for one cycle, outputs expected after its edge.
    typedef struct {
        logic        stall, rv;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                                input logic a, input logic [31:0] rd, input logic rdy,
                                input logic eq, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.stall = s;  v.rv = r;  v.rpc = rp;  v.ack = a;  v.rdata = rd;  v.ready = rdy;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
        return v;
    endfunction

    // Memory contents seen by the random phase.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h6B8B_4567;
    endfunction

    function automatic logic [31:0] tgt_of(input logic [31:0] p);
`ifdef PC_FETCH_ALIGN_CHECK_EN
        return {p[31:2], 2'b00};
`else
        return p;
`endif
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // ------------------------------------------------------------ table
        //            st rv rpc           ack rdata rdy  req addr         vld pc            instr
        vecs.push_back(mk(0,0,0,           0,0,    1,   1,32'h0,        0,32'h0,        32'h0)); // 0
        vecs.push_back(mk(0,0,0,           1,A0,   1,   0,32'h0,        1,32'h0,        A0));
        vecs.push_back(mk(0,0,0,           0,0,    1,   0,32'h0,        0,32'h0,        A0));
        vecs.push_back(mk(0,0,0,           0,0,    1,   1,32'h4,        0,32'h0,        A0));
        vecs.push_back(mk(0,0,0,           1,A1,   1,   0,32'h4,        1,32'h4,        A1));
        vecs.push_back(mk(0,0,0,           0,0,    1,   0,32'h4,        0,32'h4,        A1)); // 5
        vecs.push_back(mk(0,0,0,           0,0,    1,   1,32'h8,        0,32'h4,        A1));
        vecs.push_back(mk(0,0,0,           0,BAD,  1,   1,32'h8,        0,32'h4,        A1));
        vecs.push_back(mk(0,0,0,           0,BAD,  1,   1,32'h8,        0,32'h4,        A1));
        vecs.push_back(mk(0,0,0,           0,BAD,  1,   1,32'h8,        0,32'h4,        A1));
        vecs.push_back(mk(0,0,0,           1,A2,   1,   0,32'h8,        1,32'h8,        A2)); // 10
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,0,       0,BAD,  0,   0,32'h8,        1,32'h8,        A2));
        vecs.push_back(mk(0,0,0,           0,0,    1,   0,32'h8,        0,32'h8,        A2)); // 16
        vecs.push_back(mk(0,0,0,           0,0,    1,   1,32'hC,        0,32'h8,        A2));
        vecs.push_back(mk(0,0,0,           1,A3,   1,   0,32'hC,        1,32'hC,        A3));
        vecs.push_back(mk(0,0,0,           0,0,    1,   0,32'hC,        0,32'hC,        A3));
        vecs.push_back(mk(0,0,0,           0,0,    1,   1,32'h10,       0,32'hC,        A3)); // 20
        vecs.push_back(mk(0,1,32'h100,     0,0,    1,   1,32'h10,       0,32'hC,        A3));
        vecs.push_back(mk(0,0,0,           0,0,    1,   1,32'h10,       0,32'hC,        A3));
        vecs.push_back(mk(0,0,0,           1,BAD,  1,   0,32'h10,       0,32'hC,        A3));
        vecs.push_back(mk(0,0,0,           0,0,    1,   1,32'h100,      0,32'hC,        A3));
        vecs.push_back(mk(0,0,0,           1,A4,   1,   0,32'h100,      1,32'h100,      A4)); // 25
        vecs.push_back(mk(1,0,0,           0,0,    1,   0,32'h100,      0,32'h100,      A4));
        vecs.push_back(mk(1,0,0,           0,0,    1,   0,32'h100,      0,32'h100,      A4));
        vecs.push_back(mk(1,1,32'hFFFF_FFFC,0,0,   1,   0,32'h100,      0,32'h100,      A4));
        vecs.push_back(mk(0,0,0,           0,0,    1,   1,32'hFFFF_FFFC,0,32'h100,      A4));
        vecs.push_back(mk(0,0,0,           1,A5,   1,   0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,A5)); // 30
        vecs.push_back(mk(0,0,0,           0,0,    1,   0,32'hFFFF_FFFC,0,32'hFFFF_FFFC,A5));
        vecs.push_back(mk(0,0,0,           0,0,    1,   1,32'h0,        0,32'hFFFF_FFFC,A5));
        vecs.push_back(mk(0,1,32'h200,     1,BAD,  1,   0,32'h0,        0,32'hFFFF_FFFC,A5));
        vecs.push_back(mk(0,0,0,           0,0,    1,   1,32'h200,      0,32'hFFFF_FFFC,A5));
        vecs.push_back(mk(0,0,0,           1,A6,   1,   0,32'h200,      1,32'h200,      A6)); // 35
        vecs.push_back(mk(0,1,32'h300,     0,0,    0,   0,32'h200,      0,32'h200,      A6));
        vecs.push_back(mk(0,0,0,           0,0,    1,   1,32'h300,      0,32'h200,      A6));
        vecs.push_back(mk(0,0,0,           1,A7,   1,   0,32'h300,      1,32'h300,      A7));
        vecs.push_back(mk(0,0,0,           0,0,    1,   0,32'h300,      0,32'h300,      A7));

        // ------------------------------------------------------------ reset
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset imem_req",  u_if.imem_req,  0);
        check("reset imem_addr", u_if.imem_addr, RESET_PC);
        check("reset if_valid",  u_if.if_valid,  0);
        check("reset if_pc",     u_if.if_pc,     0);
        check("reset if_instr",  u_if.if_instr,  0);
`ifdef PC_FETCH_ALIGN_CHECK_EN
        check("reset misalign_err", misalign_err, 0);
`endif
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].ack, vecs[i].rdata, vecs[i].ready);
            step();
            check($sformatf("vec%0d imem_req",  i), u_if.imem_req,  vecs[i].e_req);
            check($sformatf("vec%0d imem_addr", i), u_if.imem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d if_valid",  i), u_if.if_valid,  vecs[i].e_valid);
            check($sformatf("vec%0d if_pc",     i), u_if.if_pc,     vecs[i].e_pc);
            check($sformatf("vec%0d if_instr",  i), u_if.if_instr,  vecs[i].e_instr);
        end

        // -------------------------------------------------- reset mid-fetch
        drive(0, 0, 0, 0, 0, 1);
        step();
        check("midrst pre imem_req",  u_if.imem_req,  1);
        check("midrst pre imem_addr", u_if.imem_addr, 32'h304);
        rst = 1'b0;
        step();
        check("midrst imem_req",  u_if.imem_req,  0);
        check("midrst imem_addr", u_if.imem_addr, RESET_PC);
        check("midrst if_valid",  u_if.if_valid,  0);
        check("midrst if_pc",     u_if.if_pc,     0);
        rst = 1'b1;

        // ------------------------------- redirect overwritten during FLUSH
        step();
        check("flush req",  u_if.imem_req,  1);
        check("flush addr", u_if.imem_addr, RESET_PC);
        drive(0, 1, 32'h400, 0, BAD, 1);
        step();
        check("flush hold1 addr", u_if.imem_addr, RESET_PC);
        drive(0, 1, 32'h500, 0, BAD, 1);
        step();
        check("flush hold2 req",  u_if.imem_req,  1);
        check("flush hold2 addr", u_if.imem_addr, RESET_PC);
        drive(0, 0, 0, 1, BAD, 1);
        step();
        check("flush done req",   u_if.imem_req, 0);
        check("flush done valid", u_if.if_valid, 0);
        drive(0, 0, 0, 0, 0, 1);
        step();
        check("flush new req",  u_if.imem_req,  1);
        check("flush new addr", u_if.imem_addr, 32'h500);
        drive(0, 0, 0, 1, A8, 1);
        step();
        check("flush new valid", u_if.if_valid, 1);
        check("flush new if_pc", u_if.if_pc,    32'h500);
        check("flush new instr", u_if.if_instr, A8);
        drive(0, 0, 0, 0, 0, 1);
        step();
        check("flush new taken", u_if.if_valid, 0);

`ifdef PC_FETCH_ALIGN_CHECK_EN
        // ---------------------------------------------- alignment check
        drive(0, 1, 32'h102, 0, 0, 1);
        step();
        check("align misalign_err", misalign_err,    1);
        check("align req",          u_if.imem_req,  1);
        check("align addr",         u_if.imem_addr, 32'h100);
        drive(0, 0, 0, 1, A9, 1);
        step();
        check("align if_pc", u_if.if_pc, 32'h100);
        drive(0, 0, 0, 0, 0, 1);
        step();
        check("align sticky", misalign_err, 1);
`endif

        // --------------------------------------------------- random phase
        begin
            logic [31:0] next_addr, cur_addr, t;
            logic        outstanding, live, prev_stall, ack, rdy, s, r;
            logic        misalign_exp;
            int          wait_cnt, transfers;
            item_t       q[$];

            rst = 1'b0;
            drive(0, 0, 0, 0, 0, 1);
            step();
            check("rand reset req", u_if.imem_req, 0);
`ifdef PC_FETCH_ALIGN_CHECK_EN
            check("rand reset misalign_err", misalign_err, 0);
`endif
            rst = 1'b1;

            next_addr    = RESET_PC;
            cur_addr     = RESET_PC;
            outstanding  = 1'b0;
            live         = 1'b0;
            prev_stall   = 1'b0;
            misalign_exp = 1'b0;
            wait_cnt     = 0;
            transfers    = 0;

            for (int c = 0; c < 3000; c++) begin
                // Outputs of this cycle.
                if (u_if.imem_req) begin
                    if (outstanding) begin
                        check("rand addr stable", u_if.imem_addr, cur_addr);
                    end else begin
                        check("rand fetch addr", u_if.imem_addr, next_addr);
                        check("rand issue after stall", prev_stall, 0);
                        cur_addr    = next_addr;
                        outstanding = 1'b1;
                        live        = 1'b1;
                        wait_cnt    = $urandom_range(0, 3);
                    end
                end
                check("rand if_valid", u_if.if_valid, (q.size() != 0) ? 1 : 0);
                check("rand req with valid", u_if.imem_req & u_if.if_valid, 0);
                if (q.size() != 0) begin
                    check("rand if_pc",    u_if.if_pc,    q[0].pc);
                    check("rand if_instr", u_if.if_instr, q[0].instr);
                end
`ifdef PC_FETCH_ALIGN_CHECK_EN
                check("rand misalign_err", misalign_err, misalign_exp);
`endif

                // Inputs for this cycle.
                s   = ($urandom_range(0, 3) == 0);
                r   = ($urandom_range(0, 19) == 0);
                t   = $urandom;
                if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
                rdy = ($urandom_range(0, 9) < 7);
                ack = 1'b0;
                if (u_if.imem_req) begin
                    if (wait_cnt == 0) ack = 1'b1;
                    else               wait_cnt--;
                end
                drive(s, r, t, ack, ack ? mem_word(cur_addr) : $urandom, rdy);

                // Model update from this cycle's events.
                if (q.size() != 0 && (rdy || r)) begin
                    if (rdy) transfers++;
                    void'(q.pop_front());
                end
                if (u_if.imem_req && ack) begin
                    outstanding = 1'b0;
                    if (live && !r) begin
                        q.push_back({cur_addr, mem_word(cur_addr)});
                        next_addr = cur_addr + 32'd4;
                    end
                    live = 1'b0;
                end
                if (r) begin
                    next_addr    = tgt_of(t);
                    live         = 1'b0;
                    misalign_exp = misalign_exp | (t[1:0] != 2'b00);
                end
                prev_stall = s;
                step();
            end
            check("rand progress", (transfers >= 100) ? 32'd1 : 32'd0, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
